// File: rtl/ppu_pkg.sv
// Shared types and helpers for the PPU pixel path: object pixel slot format
// and palette register lookup.
package ppu_pkg;

    localparam int LCD_WIDTH = 160;

    typedef struct packed {
        logic [1:0] color;
        logic       pal;
        logic       prio;
    } obj_pix_t;

    function automatic logic [1:0] pal_lookup(input logic [7:0] pal, input logic [1:0] idx);
        logic [1:0] shade;
        case (idx)
            2'd0:    shade = pal[1:0];
            2'd1:    shade = pal[3:2];
            2'd2:    shade = pal[5:4];
            default: shade = pal[7:6];
        endcase
        return shade;
    endfunction

endpackage

// File: rtl/pixel_mixer_obj_fifo.sv
// Eight-slot object pixel FIFO. A new sprite row only fills slots that are
// still transparent, so earlier (higher priority) objects keep their pixels.
module pixel_mixer_obj_fifo
    import ppu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       load,
    input  logic [7:0] load_lo,
    input  logic [7:0] load_hi,
    input  logic       load_pal,
    input  logic       load_prio,
    input  logic       shift,
    output obj_pix_t   head
);

    obj_pix_t slots      [8];
    obj_pix_t slots_next [8];

    always_comb begin
        logic [1:0] col;
        col        = 2'b00;
        slots_next = slots;
        if (clear) begin
            for (int i = 0; i < 8; i++) slots_next[i] = '0;
        end else if (load) begin
            for (int i = 0; i < 8; i++) begin
                col = {load_hi[7-i], load_lo[7-i]};
                if (slots[i].color == 2'b00 && col != 2'b00) begin
                    slots_next[i].color = col;
                    slots_next[i].pal   = load_pal;
                    slots_next[i].prio  = load_prio;
                end
            end
        end else if (shift) begin
            for (int i = 0; i < 7; i++) slots_next[i] = slots[i+1];
            slots_next[7] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) slots[i] <= '0;
        end else begin
            for (int i = 0; i < 8; i++) slots[i] <= slots_next[i];
        end
    end

    assign head = slots[0];

endmodule

// File: rtl/pixel_mixer.sv
// Background/object pixel merge and palette mapping. Holds the BG FIFO, the
// fine-scroll discard counter and the line column counter.
module pixel_mixer #(
    parameter int LCD_WIDTH = ppu_pkg::LCD_WIDTH,
    parameter int BG_DEPTH  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] bgp_d,
    input  logic [7:0] obp0_d,
    input  logic [7:0] obp1_d,
    input  logic       lcdc_bg_en,
    input  logic       lcdc_obj_en,
    input  logic [2:0] scx_fine,
    input  logic       line_start,
    input  logic       pix_en,
    input  logic       bg_valid,
    input  logic [7:0] bg_lo,
    input  logic [7:0] bg_hi,
    output logic       bg_ready,
    input  logic       obj_valid,
    input  logic [7:0] obj_lo,
    input  logic [7:0] obj_hi,
    input  logic       obj_pal,
    input  logic       obj_prio,
    output logic       pix_valid,
    output logic [1:0] pix_shade,
    output logic [7:0] pix_x,
    output logic       line_done
);
    import ppu_pkg::*;

    localparam int CW = $clog2(BG_DEPTH + 1);

    logic [1:0]    bg_fifo [BG_DEPTH];
    logic [1:0]    bg_next [BG_DEPTH];
    logic [CW-1:0] bg_count;
    logic [2:0]    discard;
    logic [7:0]    x;

    logic          bg_load;
    logic          shift_en;
    obj_pix_t      obj_head;
    logic [1:0]    bg_idx;
    logic          obj_win;
    logic [1:0]    mix_shade;

    assign bg_ready = (bg_count <= CW'(8));
    assign bg_load  = bg_valid && bg_ready && !line_start;
    assign shift_en = pix_en && (bg_count > CW'(8)) && !obj_valid &&
                      (x < 8'(LCD_WIDTH)) && !line_start;

    pixel_mixer_obj_fifo u_obj_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (line_start),
        .load      (obj_valid && !line_start),
        .load_lo   (obj_lo),
        .load_hi   (obj_hi),
        .load_pal  (obj_pal),
        .load_prio (obj_prio),
        .shift     (shift_en),
        .head      (obj_head)
    );

    // A prio object only hides behind a non-zero (after bg enable) background.
    assign bg_idx    = lcdc_bg_en ? bg_fifo[0] : 2'b00;
    assign obj_win   = lcdc_obj_en && (obj_head.color != 2'b00) &&
                       !(obj_head.prio && (bg_idx != 2'b00));
    assign mix_shade = obj_win ? pal_lookup(obj_head.pal ? obp1_d : obp0_d, obj_head.color)
                               : pal_lookup(bgp_d, bg_idx);

    always_comb begin
        bg_next = bg_fifo;
        if (bg_load) begin
            for (int j = 0; j < BG_DEPTH; j++) begin
                for (int i = 0; i < 8; i++) begin
                    if (j == int'(bg_count) + i) bg_next[j] = {bg_hi[7-i], bg_lo[7-i]};
                end
            end
        end else if (shift_en) begin
            for (int j = 0; j < BG_DEPTH - 1; j++) bg_next[j] = bg_fifo[j+1];
            bg_next[BG_DEPTH-1] = 2'b00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < BG_DEPTH; j++) bg_fifo[j] <= 2'b00;
            bg_count  <= '0;
            discard   <= '0;
            x         <= '0;
            pix_valid <= 1'b0;
            pix_shade <= 2'b00;
            pix_x     <= '0;
            line_done <= 1'b0;
        end else if (line_start) begin
            bg_count  <= '0;
            discard   <= scx_fine;
            x         <= '0;
            pix_valid <= 1'b0;
            line_done <= 1'b0;
        end else begin
            for (int j = 0; j < BG_DEPTH; j++) bg_fifo[j] <= bg_next[j];
            pix_valid <= 1'b0;
            line_done <= 1'b0;
            if (bg_load) begin
                bg_count <= bg_count + CW'(8);
            end else if (shift_en) begin
                bg_count <= bg_count - CW'(1);
                if (discard != 3'd0) begin
                    discard <= discard - 3'd1;
                end else begin
                    pix_valid <= 1'b1;
                    pix_shade <= mix_shade;
                    pix_x     <= x;
                    line_done <= (x == 8'(LCD_WIDTH - 1));
                    x         <= x + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_mixer.sv
// Scoreboard bench for pixel_mixer: expected pixels are queued as BG rows are
// issued and a negedge monitor checks every pix_valid against the queue.
module tb_pixel_mixer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] bgp_d, obp0_d, obp1_d;
    logic       lcdc_bg_en, lcdc_obj_en;
    logic [2:0] scx_fine;
    logic       line_start, pix_en;
    logic       bg_valid;
    logic [7:0] bg_lo, bg_hi;
    logic       bg_ready;
    logic       obj_valid;
    logic [7:0] obj_lo, obj_hi;
    logic       obj_pal, obj_prio;
    logic       pix_valid;
    logic [1:0] pix_shade;
    logic [7:0] pix_x;
    logic       line_done;

    pixel_mixer #(.LCD_WIDTH(160), .BG_DEPTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bgp_d       (bgp_d),
        .obp0_d      (obp0_d),
        .obp1_d      (obp1_d),
        .lcdc_bg_en  (lcdc_bg_en),
        .lcdc_obj_en (lcdc_obj_en),
        .scx_fine    (scx_fine),
        .line_start  (line_start),
        .pix_en      (pix_en),
        .bg_valid    (bg_valid),
        .bg_lo       (bg_lo),
        .bg_hi       (bg_hi),
        .bg_ready    (bg_ready),
        .obj_valid   (obj_valid),
        .obj_lo      (obj_lo),
        .obj_hi      (obj_hi),
        .obj_pal     (obj_pal),
        .obj_prio    (obj_prio),
        .pix_valid   (pix_valid),
        .pix_shade   (pix_shade),
        .pix_x       (pix_x),
        .line_done   (line_done)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [10:0] exp_q [$];   // {shade, x, line_done}

    logic [7:0] row_lo [32];
    logic [7:0] row_hi [32];
    int         n_obj;
    logic [7:0] ol [2];
    logic [7:0] oh [2];
    logic       op [2];
    logic       opr [2];

    logic [1:0] ov_col  [8];
    logic       ov_pal  [8];
    logic       ov_prio [8];
    int         spos, exp_x, cur_scx, shiftable;

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] ref_shade(input logic [1:0] bidx, input logic [1:0] ocol,
                                             input logic opal, input logic oprio);
        logic [1:0] b;
        logic [7:0] pal;
        logic [1:0] idx;
        b = lcdc_bg_en ? bidx : 2'b00;
        if (lcdc_obj_en && ocol != 2'b00 && !(oprio && b != 2'b00)) begin
            pal = opal ? obp1_d : obp0_d;
            idx = ocol;
        end else begin
            pal = bgp_d;
            idx = b;
        end
        pal = pal >> (2 * idx);
        return pal[1:0];
    endfunction

    task automatic push_row(input logic [7:0] lo, input logic [7:0] hi);
        logic [1:0] bidx, oc, sh;
        logic       opl, opp;
        for (int i = 0; i < 8; i++) begin
            bidx = {hi[7-i], lo[7-i]};
            if (spos >= cur_scx && spos < shiftable && exp_x < 160) begin
                oc  = (spos < 8) ? ov_col[spos]  : 2'b00;
                opl = (spos < 8) ? ov_pal[spos]  : 1'b0;
                opp = (spos < 8) ? ov_prio[spos] : 1'b0;
                sh  = ref_shade(bidx, oc, opl, opp);
                exp_q.push_back({sh, 8'(exp_x), exp_x == 159});
                exp_x++;
            end
            spos++;
        end
    endtask

    task automatic apply_merge(input int k);
        logic [1:0] col;
        for (int i = 0; i < 8; i++) begin
            col = {oh[k][7-i], ol[k][7-i]};
            if (ov_col[i] == 2'b00 && col != 2'b00) begin
                ov_col[i]  = col;
                ov_pal[i]  = op[k];
                ov_prio[i] = opr[k];
            end
        end
    endtask

    task automatic run_line(input int scx, input int nrows, input bit stall, input int abort_at);
        int  sent;
        bit  done;
        line_start = 1'b1;
        scx_fine   = 3'(scx);
        tick();
        line_start = 1'b0;
        spos = 0; exp_x = 0; cur_scx = scx; shiftable = nrows * 8 - 8;
        for (int i = 0; i < 8; i++) begin
            ov_col[i] = 2'b00; ov_pal[i] = 1'b0; ov_prio[i] = 1'b0;
        end
        for (int k = 0; k < n_obj; k++) apply_merge(k);
        pix_en = 1'b0;
        for (int r = 0; r < 2; r++) begin
            bg_valid = 1'b1; bg_lo = row_lo[r]; bg_hi = row_hi[r];
            push_row(row_lo[r], row_hi[r]);
            tick();
            bg_valid = 1'b0;
            chk(r == 0 ? "bg_ready_at_8" : "bg_ready_at_16", int'(bg_ready), r == 0 ? 1 : 0);
        end
        for (int k = 0; k < n_obj; k++) begin
            obj_valid = 1'b1; obj_lo = ol[k]; obj_hi = oh[k]; obj_pal = op[k]; obj_prio = opr[k];
            tick();
            obj_valid = 1'b0;
        end
        sent   = 2;
        done   = 1'b0;
        pix_en = 1'b1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            obj_valid = stall && cyc == 0;
            obj_lo = 8'h00; obj_hi = 8'h00; obj_pal = 1'b0; obj_prio = 1'b0;
            if (abort_at != 0 && cyc == abort_at) begin
                line_start = 1'b1; bg_valid = 1'b1; bg_lo = 8'hFF; bg_hi = 8'hFF;
                tick();
                line_start = 1'b0; bg_valid = 1'b0; obj_valid = 1'b0;
                chk("abort_pix_valid", int'(pix_valid), 0);
                chk("abort_bg_ready", int'(bg_ready), 1);
                exp_q.delete();
                done = 1'b1;
                break;
            end
            if (sent < nrows && bg_ready) begin
                bg_valid = 1'b1; bg_lo = row_lo[sent]; bg_hi = row_hi[sent];
                push_row(row_lo[sent], row_hi[sent]);
                sent++;
            end else begin
                bg_valid = 1'b0;
            end
            tick();
            bg_valid  = 1'b0;
            obj_valid = 1'b0;
            if (stall && cyc == 0) chk("stall_no_pixel", int'(pix_valid), 0);
            if (stall && cyc == 1) chk("pixel_after_stall", int'(pix_valid), 1);
            if (sent == nrows && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL line_timeout: got %0d pixels outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
        pix_en = 1'b0;
        repeat (3) tick();
    endtask

    task automatic fill_rows(input logic [7:0] lo, input logic [7:0] hi);
        for (int r = 0; r < 32; r++) begin
            row_lo[r] = lo; row_hi[r] = hi;
        end
    endtask

    task automatic set_obj(input int k, input logic [7:0] lo, input logic [7:0] hi,
                           input logic pal, input logic prio);
        ol[k] = lo; oh[k] = hi; op[k] = pal; opr[k] = prio;
    endtask

    always @(negedge clk) begin
        logic [10:0] e;
        if (rst_n) begin
            if (pix_valid) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_pixel: got x=%0d shade=%0d expected no pixel", pix_x, pix_shade);
                end else begin
                    e = exp_q.pop_front();
                    if ({pix_shade, pix_x, line_done} !== e)
                    begin
                        miscompares++;
                        $display("FAIL pixel: got shade=%0d x=%0d done=%0d expected shade=%0d x=%0d done=%0d",
                                 pix_shade, pix_x, line_done, e[10:9], e[8:1], e[0]);
                    end
                end
            end else if (line_done) begin
                vectors++;
                miscompares++;
                $display("FAIL line_done_without_pixel: got 1 expected 0");
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        bgp_d = 8'hE4; obp0_d = 8'h1B; obp1_d = 8'hE4;
        lcdc_bg_en = 1'b1; lcdc_obj_en = 1'b1;
        scx_fine = 3'd0; line_start = 1'b0; pix_en = 1'b0;
        bg_valid = 1'b0; bg_lo = 8'h00; bg_hi = 8'h00;
        obj_valid = 1'b0; obj_lo = 8'h00; obj_hi = 8'h00; obj_pal = 1'b0; obj_prio = 1'b0;
        n_obj = 0;
        fill_rows(8'h00, 8'h00);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("reset_bg_ready", int'(bg_ready), 1);
        chk("reset_pix_valid", int'(pix_valid), 0);
        chk("reset_pix_shade", int'(pix_shade), 0);
        chk("reset_pix_x", int'(pix_x), 0);
        chk("reset_line_done", int'(line_done), 0);

        // full line of index 1 through BGP E4
        fill_rows(8'hFF, 8'h00);
        run_line(0, 22, 1'b0, 0);

        // fine scroll: source pixel 5 is the first one shown
        fill_rows(8'h00, 8'h00);
        row_lo[0] = 8'h84;
        run_line(5, 4, 1'b0, 0);

        // opaque object index 3 over background index 0
        fill_rows(8'h00, 8'h00);
        n_obj = 1; set_obj(0, 8'hFF, 8'hFF, 1'b0, 1'b0);
        run_line(0, 4, 1'b0, 0);

        // behind-BG object over non-zero BG, then over zero BG
        bgp_d = 8'hE7; obp0_d = 8'hD2;
        fill_rows(8'h00, 8'hFF);
        set_obj(0, 8'hFF, 8'h00, 1'b0, 1'b1);
        run_line(0, 4, 1'b0, 0);
        fill_rows(8'h00, 8'h00);
        run_line(0, 4, 1'b0, 0);

        // objects disabled
        lcdc_obj_en = 1'b0;
        set_obj(0, 8'hFF, 8'hFF, 1'b0, 1'b0);
        run_line(0, 4, 1'b0, 0);
        lcdc_obj_en = 1'b1;

        // background disabled lets a prio object through
        lcdc_bg_en = 1'b0;
        fill_rows(8'h00, 8'hFF);
        set_obj(0, 8'hFF, 8'h00, 1'b0, 1'b1);
        run_line(0, 4, 1'b0, 0);
        lcdc_bg_en = 1'b1;

        // two overlapping objects: first keeps slots 0-3
        fill_rows(8'h00, 8'h00);
        n_obj = 2;
        set_obj(0, 8'hF0, 8'h00, 1'b0, 1'b0);
        set_obj(1, 8'hFF, 8'h00, 1'b1, 1'b0);
        run_line(0, 4, 1'b0, 0);

        // object load stalls shifting for one cycle
        n_obj = 0;
        run_line(0, 4, 1'b1, 0);

        // abort mid-line, then a fresh line restarts at column 0
        bgp_d = 8'hE4;
        fill_rows(8'hFF, 8'h00);
        run_line(0, 22, 1'b0, 40);
        run_line(0, 4, 1'b0, 0);

        repeat (4) tick();
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pixel_mixer.md
# pixel_mixer

Downstream consumer of the BGP/OBP0/OBP1 palette registers. Holds the background pixel FIFO and the object pixel FIFO, merges object pixels over background with DMG transparency and priority rules, and maps the winning 2-bit colour index through the selected palette to a 2-bit LCD shade. Emits one registered pixel per shift, discards fine-scroll pixels at line start and counts 160 pixels per line.

## Interface
Parameters:
- LCD_WIDTH, 160, visible pixels per line
- BG_DEPTH, 16, background FIFO entries (two tiles)

Ports (clock and reset first):
- clk  in  1  PPU pixel clock
- rst_n  in  1  asynchronous, active-low reset
- bgp_d, obp0_d, obp1_d  in  8 each  palette register contents; index n maps to bits [2n+1:2n]
- lcdc_bg_en  in  1  0 forces background index to 0
- lcdc_obj_en  in  1  0 hides all object pixels
- scx_fine  in  3  pixels to discard after line_start
- line_start  in  1  one-cycle pulse: clear FIFOs and counters, load discard count
- pix_en  in  1  mode-3 enable for shifting
- bg_valid, bg_lo, bg_hi  in  1/8/8  tile row; bit 7 is leftmost pixel
- bg_ready  out  1  high when bg_count <= 8
- obj_valid, obj_lo, obj_hi, obj_pal, obj_prio  in  1/8/8/1/1  sprite row merge request; obj_pal 1 selects OBP1, obj_prio 1 means behind non-zero BG
- pix_valid  out  1  pix_shade/pix_x valid this cycle
- pix_shade  out  2  LCD shade
- pix_x  out  8  column of the emitted pixel
- line_done  out  1  one-cycle pulse after pixel LCD_WIDTH-1 is emitted

## Operation
- Priority per cycle: reset, then line_start, then obj load, then bg load, then shift.
- line_start: bg_count=0, all object slots colour 0, discard=scx_fine, x=0, emitting enabled. Loads and shift that cycle are ignored.
- BG load: transfer on bg_valid && bg_ready; appends 8 pixels behind existing ones; bg_count += 8. bg_valid without bg_ready is ignored.
- Obj load: unconditional when obj_valid (upstream only asserts once bg_count > 8). For each slot i in 0..7, overwrite only if current slot colour is 0 and incoming colour is non-zero; overwrite sets colour, pal, prio. The shift is suppressed that cycle.
- Shift: when pix_en && bg_count > 8 && !obj_valid && x < LCD_WIDTH. Pops BG head and object slot 0 (object FIFO shifts in a colour-0 slot); bg_count -= 1.
- Discard: if discard != 0, the shift decrements discard; no pixel emitted, x unchanged.
- Mix on an emitting shift: b = lcdc_bg_en ? bg_idx : 0; object wins when lcdc_obj_en && o_idx != 0 && !(o_prio && b != 0). Shade = winning palette at winning index (BGP for background, OBP0/OBP1 for object). Palettes are sampled on the shift cycle, so a mid-line palette write affects the next shifted pixel.
- x increments per emitted pixel and saturates at LCD_WIDTH. Once x == LCD_WIDTH, no further shifts occur until the next line_start.

## Timing
- Reset values: bg_ready=1, pix_valid=0, pix_shade=0, pix_x=0, line_done=0; FIFOs empty; discard=0; x=0.
- Latency: pixel outputs are registered and valid the cycle after the emitting shift.
- line_done is asserted in the same cycle as pix_valid for pix_x == LCD_WIDTH-1.
- bg_ready is combinational from bg_count.
- Throughput: 1 pixel/cycle while bg_count > 8 and no obj load.
- A line_start during a line clears everything with no partial output; pix_valid is 0 on the following cycle.

## Structure
- Package ppu_pkg holds:
  - LCD_WIDTH
  - obj_pix_t {color[1:0], pal, prio}
  - the pal_lookup(pal[7:0], idx[1:0]) function
- Sub-module pixel_mixer_obj_fifo holds the 8-slot object FIFO with merge and shift. The top level holds the BG FIFO, counters and mix logic.

## Test plan
- Reset, then line_start with scx_fine=0, bgp_d=8'hE4, BG rows lo=8'hFF hi=8'h00 streamed: 160 pix_valid pulses, all shade 1; pix_x 0..159; one line_done at pix_x=159.
- scx_fine=5, first row lo=8'h80: the first emitted pixel is the source's sixth pixel; pix_x=0; 5 shifts produce no pix_valid.
- bgp_d=8'hE4, obp0_d=8'h1B, bg index 0, obj lo=8'hFF hi=8'hFF pal=0 prio=0: obj index 3 → shade 0 for 8 pixels.
- BG index 2 with obj index 1 prio=1: BG shade shown; same with BG index 0: OBP shade shown. lcdc_obj_en=0 → always BG.
- Two obj loads on same slots (first lo=8'hF0, second lo=8'hFF pal=1): slots 0-3 keep first object's OBP0 shade, slots 4-7 take OBP1; each load stalls the shift one cycle.
- line_start asserted mid-line with bg_valid high: next cycle pix_valid=0, bg_ready=1, pix_x restarts at 0.
